floating_point_multiplier_iterative: RTL and testbench

FLOATING_POINT_MULTIPLIER_ITERATIVE -- requirements
Module: floating_point_multiplier_iterative

---
 rtl/fp_mul_pkg.sv | 43 ++++
 rtl/fp_mant_shift_add.sv | 73 +++++++
 rtl/floating_point_multiplier_iterative.sv | 186 ++++++++++++++++++
 tb/tb_floating_point_multiplier_iterative.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared definitions for the iterative floating-point multiplier.
//   - state_t   : controller states (IDLE, MUL, NORM, DONE)
//   - bias_of   : exponent bias for a given exponent width
//   - qnan_of   : canonical quiet-NaN bit pattern for given field widths
//   - exp_field / frac_field / sign_field : field extraction from a packed
//     operand that has been zero-extended to FIELD_W bits
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the helpers below can take apart.
  localparam int FIELD_W = 64;

  function automatic int bias_of(input int exp_w);
    return (32'sd1 << (exp_w - 32'sd1)) - 32'sd1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set, remaining fraction bits 0.
  function automatic logic [FIELD_W-1:0] qnan_of(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'sd1));
  endfunction

  function automatic logic [FIELD_W-1:0] exp_field(input logic [FIELD_W-1:0] v,
                                                   input int exp_w, input int man_w);
    return (v >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [FIELD_W-1:0] frac_field(input logic [FIELD_W-1:0] v,
                                                    input int man_w);
    return v & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic sign_field(input logic [FIELD_W-1:0] v,
                                      input int exp_w, input int man_w);
    return v[exp_w + man_w];
  endfunction

endpackage

// File: rtl/fp_mant_shift_add.sv
// fp_mant_shift_add: iterative shift-add mantissa multiplier.
// A start pulse loads both operands; each following cycle retires BPC
// multiplier bits into the product. done is high during the cycle in which
// the last bits are retired, so product is complete after that edge.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start           load mcand/mplier and begin
//   mcand, mplier   MW-bit mantissas (hidden bit included)
//   done            last retire happens at the coming edge
//   product         2*MW-bit accumulated product
module fp_mant_shift_add #(
  parameter int MW  = 24,
  parameter int BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MW-1:0]   mcand,
  input  logic [MW-1:0]   mplier,
  output logic            done,
  output logic [2*MW-1:0] product
);

  localparam int N  = MW / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*MW-1:0] mcand_r;
  logic [MW-1:0]   mplr_r;
  logic [2*MW-1:0] prod_r;
  logic [CW-1:0]   cnt_r;
  logic            run_r;
  logic [2*MW-1:0] partial_s;

  // Sum of the multiplicand copies selected by the low BPC multiplier bits.
  always_comb begin
    partial_s = '0;
    for (int j = 0; j < BPC; j++) begin
      if (mplr_r[j]) begin
        partial_s = partial_s + (mcand_r << j);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  // Operand load on start, then one BPC-bit retire per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_r <= '0;
      mplr_r  <= '0;
      prod_r  <= '0;
      cnt_r   <= '0;
      run_r   <= 1'b0;
    end else if (start) begin
      mcand_r <= {{MW{1'b0}}, mcand};
      mplr_r  <= mplier;
      prod_r  <= '0;
      cnt_r   <= '0;
      run_r   <= 1'b1;
    end else if (run_r) begin
      prod_r  <= prod_r + partial_s;
      mcand_r <= mcand_r << BPC;
      mplr_r  <= mplr_r >> BPC;
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      run_r   <= (cnt_r != LAST);
    end
  end

  assign done    = run_r && (cnt_r == LAST);
  assign product = prod_r;

endmodule

// File: rtl/floating_point_multiplier_iterative.sv
// floating_point_multiplier_iterative: multi-cycle IEEE-style multiplier.
// Accepts one operand pair at a time; result appears N+2 edges after the
// accepting edge (N = (MAN_W+1)/BPC), special cases included.
// Denormal inputs are flushed to zero.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  operands
//   out_valid / out_ready result handshake
//   result                product, held stable until taken
//   overflow, underflow   exponent range flags
//   busy                  controller not in IDLE
// Build option: define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the fraction is truncated.
module floating_point_multiplier_iterative
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BPC   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     busy
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam logic [EXP_W+1:0] BIAS_V = (EXP_W+2)'(bias_of(EXP_W));
  localparam logic [W-1:0]     QNAN_V = W'(qnan_of(EXP_W, MAN_W));
`ifdef FPMUL_ROUND_NEAREST_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t            state_r, state_nx_s;
  logic [W-1:0]      a_r, b_r;
  logic [W-1:0]      result_r;
  logic              overflow_r, underflow_r, out_valid_r;
  logic              accept_s, mul_done_s;
  logic [2*MW-1:0]   prod_s;

  logic              sign_s;
  logic [EXP_W-1:0]  ea_s, eb_s;
  logic [MAN_W-1:0]  fa_s, fb_s;
  logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic              hi_s, guard_s, sticky_s, round_up_s, carry_s;
  logic [MAN_W-1:0]  frac_s, frac_rnd_s;
  logic [EXP_W+1:0]  exp_fin_s;   // two's complement, sign in the top bit
  logic              exp_ovf_s, exp_unf_s;
  logic [W-1:0]      res_s;
  logic              ovf_s, unf_s;

  assign accept_s  = in_valid && (state_r == IDLE);
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  fp_mant_shift_add #(.MW(MW), .BPC(BPC)) u_mant (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s),
    .mcand   ({1'b1, a[MAN_W-1:0]}),
    .mplier  ({1'b1, b[MAN_W-1:0]}),
    .done    (mul_done_s),
    .product (prod_s)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: if (in_valid) state_nx_s = MUL; else state_nx_s = IDLE;
      MUL:  if (mul_done_s) state_nx_s = NORM; else state_nx_s = MUL;
      NORM: state_nx_s = DONE;
      DONE: if (out_valid_r && out_ready) state_nx_s = IDLE; else state_nx_s = DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand classification from the captured operands.
  always_comb begin
    sign_s   = sign_field(FIELD_W'(a_r), EXP_W, MAN_W) ^ sign_field(FIELD_W'(b_r), EXP_W, MAN_W);
    ea_s     = EXP_W'(exp_field(FIELD_W'(a_r), EXP_W, MAN_W));
    eb_s     = EXP_W'(exp_field(FIELD_W'(b_r), EXP_W, MAN_W));
    fa_s     = MAN_W'(frac_field(FIELD_W'(a_r), MAN_W));
    fb_s     = MAN_W'(frac_field(FIELD_W'(b_r), MAN_W));
    a_zero_s = (ea_s == '0);
    b_zero_s = (eb_s == '0);
    a_inf_s  = (&ea_s) && (fa_s == '0);
    b_inf_s  = (&eb_s) && (fb_s == '0);
    a_nan_s  = (&ea_s) && (fa_s != '0);
    b_nan_s  = (&eb_s) && (fb_s != '0);
  end

  // Normalisation: the product of two [1,2) mantissas lies in [1,4), so the
  // leading one is at one of the two top bit positions.
  always_comb begin
    hi_s = prod_s[2*MW-1];
    if (hi_s) begin
      frac_s   = prod_s[2*MAN_W:MAN_W+1];
      guard_s  = prod_s[MAN_W];
      sticky_s = |prod_s[MAN_W-1:0];
    end else begin
      frac_s   = prod_s[2*MAN_W-1:MAN_W];
      guard_s  = prod_s[MAN_W-1];
      sticky_s = |prod_s[MAN_W-2:0];
    end
    // Nearest-even: round up on guard unless exactly halfway with even LSB.
    round_up_s = ROUND_EN & guard_s & (sticky_s | frac_s[0]);
    {carry_s, frac_rnd_s} = {1'b0, frac_s} + {{MAN_W{1'b0}}, round_up_s};
    // A rounding carry turns 1.11..1 into 10.0: fraction is already 0, bump exponent.
    exp_fin_s = {2'b00, ea_s} + {2'b00, eb_s} - BIAS_V
              + {{(EXP_W+1){1'b0}}, hi_s} + {{(EXP_W+1){1'b0}}, carry_s};
    exp_ovf_s = !exp_fin_s[EXP_W+1] && (exp_fin_s[EXP_W] || (&exp_fin_s[EXP_W-1:0]));
    exp_unf_s = exp_fin_s[EXP_W+1] || (exp_fin_s == '0);
  end

  // Result selection, special operands first.
  always_comb begin
    res_s = '0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
      res_s = QNAN_V;
    end else if (a_inf_s || b_inf_s) begin
      res_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero_s || b_zero_s) begin
      res_s = {sign_s, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_ovf_s) begin
      res_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_s = 1'b1;
    end else if (exp_unf_s) begin
      res_s = {sign_s, {(EXP_W+MAN_W){1'b0}}};
      unf_s = 1'b1;
    end else begin
      res_s = {sign_s, exp_fin_s[EXP_W-1:0], frac_rnd_s};
    end
  end

  // Operand capture, result registers and output valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r <= a;
        b_r <= b;
      end
      if (state_r == NORM) begin
        result_r    <= res_s;
        overflow_r  <= ovf_s;
        underflow_r <= unf_s;
      end
      out_valid_r <= (state_r == DONE) && !(out_valid_r && out_ready);
    end
  end

endmodule

// File: tb/tb_floating_point_multiplier_iterative.sv
// Directed-vector bench with a scoreboard: the driver pushes expected
// results as operands are accepted, a monitor pops and compares them when
// the result handshake happens and checks the accept-to-valid latency.
module tb_floating_point_multiplier_iterative;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BPC   = 1;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int LAT   = (MAN_W + 1) / BPC + 2;

`ifdef FPMUL_ROUND_NEAREST_EN
  localparam logic [W-1:0] R_RND = 32'h40100002;
`else
  localparam logic [W-1:0] R_RND = 32'h40100001;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, overflow, underflow, busy;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  floating_point_multiplier_iterative #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BPC(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data at handshake.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_valid: got 1 want 0 (cycle %0d)", cyc);
      end else begin
        chk("latency", W'(cyc - exp_q[0].acc), W'(LAT));
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
      chk("result", result, exp_q[0].res);
      chk1("overflow", overflow, exp_q[0].ovf);
      chk1("underflow", underflow, exp_q[0].unf);
      void'(exp_q.pop_front());
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] r, input logic o, input logic u, input bit push);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got %b want 1", in_ready);
    end else begin
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) exp_q.push_back('{r, o, u, cyc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_underflow", underflow, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_result", result, {W{1'b0}});
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    send(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b1);
    send(32'h3FC00001, 32'h3FC00001, R_RND,        1'b0, 1'b0, 1'b1);
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
    send(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b1);
    send(32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
    send(32'hBF800000, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 1'b1);
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b1);
    send(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 1'b1);
    send(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
    send(32'h7F800001, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
    send(32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 1'b1);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
    send(32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 1'b1);
    send(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 1'b1);
    send(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
    send(32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 1'b0, 1'b1);
    send(32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, 1'b1);

    // Back-pressure: result must hold and no new operand may be taken.
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    send(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("stall_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_result", result, 32'h40C00000);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // Reset in the middle of MUL discards the operation.
    send(32'h40000000, 32'h40400000, {W{1'b0}}, 1'b0, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk1("abort_busy_before", busy, 1'b1);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy_after", busy, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk1("abort_no_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Recovery after the aborted operation.
    send(32'hC0000000, 32'hC0400000, 32'h40C00000, 1'b0, 1'b0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
